// File: rtl/ethernet_tx_sched.sv
// ethernet_tx_sched: queues bus read responses and launches one mac_tx frame
// per word, spacing frames by the txen feedback plus an inter-frame gap.
// Optional feature: define ETHERNET_TX_SCHED_TIMEOUT_EN to abandon a launch
// that never sees txen rise within START_TIMEOUT cycles (sets timeout_o).
module ethernet_tx_sched #(
   parameter int DEPTH         = 8,
   parameter int IFG_CYCLES    = 48,
   parameter int START_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [15:0]              rdata_i,
   input  logic                     rw_i,
   input  logic                     valid_i,
   output logic [15:0]              mac_data_o,
   output logic                     mac_start_o,
   input  logic                     mac_txen_i,
   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   pending_o,
   output logic                     overflow_o,
   output logic                     timeout_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_MAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TXEN,
      SEND,
      GAP
   } state_t;

   state_t             state;
   logic [15:0]        mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     count;
   logic [CNT_W-1:0]   cnt;

   logic push;
   logic pop;
   logic empty;
   logic full;
   logic accept;

   assign push   = valid_i && !rw_i;
   assign empty  = (count == '0);
   assign full   = (count == (PTR_W + 1)'(DEPTH));
   // The head leaves the FIFO in the same cycle the FSM launches it.
   assign pop    = (state == IDLE) && !empty;
   // A full FIFO still takes a word when the head is leaving on the same edge.
   assign accept = push && (!full || pop);
   assign busy_o = (state != IDLE) || !empty;

   // Payload storage written at the tail.
   // NOTE: the data array has no reset; a slot is only read after it has been
   // written, so clearing it would cost flops and buy nothing.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= rdata_i;
      end
   end

   // FIFO pointers, occupancy, the lagging occupancy output and the drop flag.
   // NOTE: every sequential assignment is non-blocking so all registers in the
   // design see the pre-edge values of each other, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pending_o  <= '0;
         overflow_o <= 1'b0;
      end else begin
         pending_o <= count;
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && full && !pop) begin
            overflow_o <= 1'b1;
         end
      end
   end

   // Launch FSM: pop and pulse start, wait for txen, follow the frame, then
   // hold off for the inter-frame gap. All outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         mac_data_o  <= '0;
         mac_start_o <= 1'b0;
`ifdef ETHERNET_TX_SCHED_TIMEOUT_EN
         timeout_o   <= 1'b0;
`endif
      end else begin
         mac_start_o <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  mac_data_o  <= mem[rd_ptr];
                  mac_start_o <= 1'b1;
                  state       <= WAIT_TXEN;
`ifdef ETHERNET_TX_SCHED_TIMEOUT_EN
                  cnt         <= CNT_W'(START_TIMEOUT - 1);
`endif
               end
            end
            WAIT_TXEN: begin
               if (mac_txen_i) begin
                  state <= SEND;
               end
`ifdef ETHERNET_TX_SCHED_TIMEOUT_EN
               else if (cnt == '0) begin
                  timeout_o <= 1'b1;
                  state     <= GAP;
                  cnt       <= CNT_W'(IFG_CYCLES - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
`endif
            end
            SEND: begin
               if (!mac_txen_i) begin
                  state <= GAP;
                  cnt   <= CNT_W'(IFG_CYCLES - 1);
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef ETHERNET_TX_SCHED_TIMEOUT_EN
   // Without the timeout feature a launch can never be abandoned.
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ethernet_tx_sched.sv
// Scoreboard bench for ethernet_tx_sched: reads push their expected payload
// into a queue, a negedge monitor pops and compares on every start pulse.
module tb_ethernet_tx_sched;

   localparam int IFG_CYCLES = 48;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] rdata;
   logic        rw;
   logic        valid;
   logic [15:0] mac_data;
   logic        mac_start;
   logic        mac_txen;
   logic        busy;
   logic [3:0]  pending;
   logic        overflow;
   logic        timeout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int launches = 0;
   int peak     = 0;
   int fall_cyc = 0;
   bit armed    = 1'b0;
   bit manual_mode = 1'b0;
   bit prev_start  = 1'b0;
   logic [15:0] exp_q [$];

   ethernet_tx_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rdata_i     (rdata),
      .rw_i        (rw),
      .valid_i     (valid),
      .mac_data_o  (mac_data),
      .mac_start_o (mac_start),
      .mac_txen_i  (mac_txen),
      .busy_o      (busy),
      .pending_o   (pending),
      .overflow_o  (overflow),
      .timeout_o   (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // mac_tx model: txen rises 2 cycles after start and stays high 20 cycles.
   initial begin
      int dly;
      int left;
      dly = 0;
      left = 0;
      mac_txen = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!manual_mode) begin
            if (!rst_n) begin
               mac_txen = 1'b0;
               dly = 0;
               left = 0;
               armed = 1'b0;
            end else if (mac_start) begin
               dly = 2;
            end else if (dly > 0) begin
               dly--;
               if (dly == 0) begin
                  mac_txen = 1'b1;
                  left = 20;
               end
            end else if (left > 0) begin
               left--;
               if (left == 0) begin
                  mac_txen = 1'b0;
                  fall_cyc = cyc;
                  armed = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: every start pulse must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mac_start) begin
            check("start_width", {31'd0, prev_start}, 32'd0);
            check("launch_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               check("launch_data", {16'd0, mac_data}, {16'd0, exp_q.pop_front()});
            end
            if (armed) begin
               check("launch_spacing", {31'd0, (cyc - fall_cyc) > IFG_CYCLES}, 32'd1);
               armed = 1'b0;
            end
            launches++;
         end
         if (int'(pending) > peak) peak = int'(pending);
         prev_start = mac_start;
      end else begin
         prev_start = 1'b0;
      end
   end

   task automatic rd(input logic [15:0] d, input bit keep);
      valid = 1'b1;
      rw    = 1'b0;
      rdata = d;
      if (keep) exp_q.push_back(d);
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},     {16'd0, mac_data}, 32'd0);
      check({tag, "_start"},    {31'd0, mac_start}, 32'd0);
      check({tag, "_busy"},     {31'd0, busy}, 32'd0);
      check({tag, "_pending"},  {28'd0, pending}, 32'd0);
      check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
      check({tag, "_timeout"},  {31'd0, timeout}, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      exp_q.delete();
      rst_n = 1'b0;
      armed = 1'b0;
      #1;
      check_reset_outputs(tag);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({tag, "_drain"}, {31'd0, busy}, 32'd0);
      check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      valid = 1'b0;
      rw    = 1'b0;
      rdata = 16'h0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single read: start one cycle after capture, occupancy lags one edge.
      base = launches;
      rd(16'hBEEF, 1'b1);
      @(negedge clk);
      check("single_start_early", {31'd0, mac_start}, 32'd0);
      check("single_pend_0", {28'd0, pending}, 32'd0);
      @(negedge clk);
      check("single_start", {31'd0, mac_start}, 32'd1);
      check("single_data", {16'd0, mac_data}, 32'h0000_BEEF);
      check("single_pend_1", {28'd0, pending}, 32'd1);
      @(negedge clk);
      check("single_start_end", {31'd0, mac_start}, 32'd0);
      check("single_pend_2", {28'd0, pending}, 32'd0);
      wait_idle("single");
      check("single_count", launches - base, 32'd1);

      // Three back-to-back reads: occupancy peaks at 2, launches in order.
      peak = 0;
      base = launches;
      rd(16'h0001, 1'b1);
      rd(16'h0002, 1'b1);
      rd(16'h0003, 1'b1);
      wait_idle("triple");
      check("triple_peak", peak, 32'd2);
      check("triple_count", launches - base, 32'd3);

      // Launch with txen never rising.
      manual_mode = 1'b1;
      mac_txen = 1'b0;
      base = launches;
      rd(16'h00AA, 1'b1);
      rd(16'h00BB, 1'b1);
      @(negedge clk);
      check("to_launch", {31'd0, mac_start}, 32'd1);
`ifdef ETHERNET_TX_SCHED_TIMEOUT_EN
      repeat (15) @(negedge clk);
      check("to_before", {31'd0, timeout}, 32'd0);
      @(negedge clk);
      check("to_set", {31'd0, timeout}, 32'd1);
      wait_idle("to");
      check("to_count", launches - base, 32'd2);
      check("to_sticky", {31'd0, timeout}, 32'd1);
`else
      repeat (100) @(negedge clk);
      check("to_flag_off", {31'd0, timeout}, 32'd0);
      check("to_stuck_busy", {31'd0, busy}, 32'd1);
      check("to_stuck_pend", {28'd0, pending}, 32'd1);
      check("to_stuck_count", launches - base, 32'd1);
      @(posedge clk);
      #1;
`endif
      do_reset("rst_a");

      // Overflow: one word in flight, nine more offered, the ninth is dropped.
      rd(16'h1000, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) begin
         rd(16'hA000 + 16'(i), i < 8);
      end
      @(negedge clk);
      check("ovf_set", {31'd0, overflow}, 32'd1);
      @(negedge clk);
      check("ovf_pend", {28'd0, pending}, 32'd8);
      @(posedge clk);
      #1;
      valid = 1'b1;
      rw    = 1'b1;
      rdata = 16'hFFFF;
      repeat (4) begin
         @(negedge clk);
         check("ovf_write_pend", {28'd0, pending}, 32'd8);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
      rw    = 1'b0;
      repeat (3) @(negedge clk);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      @(posedge clk);
      #1;
      do_reset("rst_b");

      // Full FIFO with push and pop on the same edge.
      for (int i = 0; i < 9; i++) begin
         rd(16'hB000 + 16'(i), 1'b1);
      end
      mac_txen = 1'b1;
      repeat (2) @(negedge clk);
      check("full_pend", {28'd0, pending}, 32'd8);
      check("full_no_ovf", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      #1;
      mac_txen = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      rd(16'hB009, 1'b1);
      @(negedge clk);
      check("full_pop_start", {31'd0, mac_start}, 32'd1);
      check("full_pend_a", {28'd0, pending}, 32'd8);
      @(negedge clk);
      check("full_pend_b", {28'd0, pending}, 32'd8);
      check("full_ovf_b", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      #1;
      do_reset("rst_c");

      // Reset during SEND with four words queued.
      manual_mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd(16'hE000 + 16'(i), 1'b1);
      end
      repeat (4) @(posedge clk);
      #1;
      check("mid_pend", {28'd0, pending}, 32'd4);
      check("mid_txen_high", {31'd0, mac_txen}, 32'd1);
      base = launches;
      do_reset("rst_mid");
      repeat (60) @(negedge clk);
      check("mid_no_launch", launches - base, 32'd0);
      check("mid_pend_0", {28'd0, pending}, 32'd0);
      @(posedge clk);
      #1;
      rd(16'hC0DE, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("mid_new_start", {31'd0, mac_start}, 32'd1);
      check("mid_new_data", {16'd0, mac_data}, 32'h0000_C0DE);
      wait_idle("mid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ethernet_tx_sched.md
# ethernet_tx_sched

Transmit scheduler between the bus read-response path and `mac_tx`. Captures each read response (`valid_i && ~rw_i`) into a small FIFO and launches one `mac_tx` frame per word, spacing frames by watching `txen` plus a programmable inter-frame gap, so back-to-back responses are never lost. Replaces the direct response-to-`start` connection inside the Ethernet transmit wrapper; `mac_tx` itself is unchanged and still uses ethertype 16'h2.

## Interface

- `DEPTH`, 8: FIFO depth in words; power of two, ≥2.
- `IFG_CYCLES`, 48: idle `clk` cycles enforced after `txen` falls (96 bit-times at 2 bits/cycle).
- `START_TIMEOUT`, 16: cycles to wait for `txen` to rise after a launch (used only with the timeout feature).

- `clk` in 1: single clock, the RMII reference clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rdata_i` in 16: read-response data.
- `rw_i` in 1: 1 = write, 0 = read; only reads are queued.
- `valid_i` in 1: bus transaction strobe.
- `mac_data_o` out 16: frame payload to `mac_tx.data`; registered.
- `mac_start_o` out 1: one-cycle launch pulse to `mac_tx.start`; registered.
- `mac_txen_i` in 1: `txen` fed back from `mac_tx`.
- `busy_o` out 1: high whenever state ≠ IDLE or FIFO non-empty.
- `pending_o` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow_o` out 1: sticky, a response was dropped.
- `timeout_o` out 1: sticky, a launch got no `txen`.

## Operation

- Push: `valid_i && ~rw_i` writes `rdata_i` at FIFO tail. Writes (`rw_i`=1) ignored.
- Full: push with FIFO full and no same-cycle pop → word dropped, `overflow_o` set; contents unchanged. Push and pop in the same cycle while full → both succeed, occupancy unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is one bit wider.
- FSM states:
  - IDLE: FIFO non-empty → pop head into `mac_data_o`, assert `mac_start_o` for one cycle, go WAIT_TXEN, load timeout counter with START_TIMEOUT-1. Otherwise stay.
  - WAIT_TXEN: `mac_txen_i`=1 → SEND. Counter reaches 0 with `txen` still low → set `timeout_o`, go GAP.
  - SEND: `mac_txen_i`=0 → GAP, load gap counter with IFG_CYCLES-1.
  - GAP: decrement; at 0 → IDLE.
- `mac_data_o` holds the launched word from launch until the next launch.
- Empty: IDLE with FIFO empty keeps `mac_start_o` low; no underflow is possible.
- Flags clear only on reset.

## Timing

- Reset (async, `rst_n`=0): state IDLE, FIFO empty, `mac_data_o`=0, `mac_start_o`=0, `busy_o`=0, `pending_o`=0, `overflow_o`=0, `timeout_o`=0, all counters 0. Reset mid-frame drops the queued words and any word in flight; the first post-reset launch still waits for an empty FIFO entry only, with no gap.
- Latency: push at edge N into empty FIFO with FSM in IDLE → `mac_start_o` high in cycle N+1..N+2 (one cycle after capture), `pending_o` returns to 0 at edge N+2.
- `pending_o` reflects pushes and pops one edge after the event.
- Min launch-to-launch spacing: frame length (`txen` high time) + IFG_CYCLES + 3 cycles.

## Configuration

- `ETHERNET_TX_SCHED_TIMEOUT_EN` defined: WAIT_TXEN timeout active as described; `timeout_o` functional.
- Not defined: WAIT_TXEN waits indefinitely for `txen`; START_TIMEOUT unused; `timeout_o` tied 0.

## Test plan

- Single read `rdata_i`=16'hBEEF, `mac_txen_i` model high 20 cycles from 2 cycles after start → exactly one start pulse one cycle after capture, `mac_data_o`=16'hBEEF, next launch not before 48 idle cycles.
- Three consecutive-cycle reads 16'h0001/0002/0003 → `pending_o` peaks at 2, three launches in order, each separated by ≥IFG_CYCLES after `txen` falls.
- Nine reads with txen model stalled (DEPTH=8) → 8 queued, ninth dropped, `overflow_o`=1 and stays 1; write strobes (`rw_i`=1) never change `pending_o`.
- Full FIFO, push coincident with pop → `pending_o` stays 8, `overflow_o` stays 0.
- Macro defined, `mac_txen_i` held 0 → `timeout_o`=1 exactly 16 cycles after launch, FSM passes GAP and launches next word; macro undefined → FSM stays in WAIT_TXEN, `timeout_o`=0.
- `rst_n` pulsed low during SEND with 4 words queued → all outputs at reset values immediately, no start pulse until a new read arrives.
